comparador_bist: RTL
====================

Name: comparador_bist

Overview:
Synthesizable built-in self-test controller that acts as the stimulus and checking side of an N-bit magnitude comparator (maior/menor/igual flags).
- Sweeps all 2^(2N) (a,b) pairs exhaustively.
- Waits a programmable settle time, samples the DUT flags and checks them against the golden relation.
- Counts mismatches, captures the first failing vector and reports done/pass.
- Sits next to the comparator in the comparator test harness. Replaces hand-written vector lists with on-chip sweeping.

Parameters:
N, 1, comparator operand width in bits (1..8)
LAT, 0, extra settle cycles between driving a vector and sampling the flags (0..15)
ERR_W, 8, width of the error counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
iniciar  in  1  start pulse; sampled only in OCIOSO or FIM
a_out  out  N  operand a driven to the DUT
b_out  out  N  operand b driven to the DUT
maior_in  in  1  DUT flag a>b
menor_in  in  1  DUT flag a<b
igual_in  in  1  DUT flag a==b
ocupado  out  1  sweep in progress
concluido  out  1  sweep finished; holds until the next start or reset
aprovado  out  1  valid when concluido; 1 iff erros==0
erros  out  ERR_W  mismatch count, saturating
falha_a  out  N  a of the first failing vector
falha_b  out  N  b of the first failing vector

Behaviour:
- Reset (async, rst=1): state OCIOSO; a_out=0, b_out=0, ocupado=0, concluido=0, aprovado=0, erros=0, falha_a=0, falha_b=0, settle counter=0.
- All outputs are registered.
- Vector index: 2N-bit register {a,b}. b is the inner loop, so the order is (0,0),(0,1)…(0,max),(1,0)…(max,max).
- States:
  - OCIOSO: iniciar=1 -> APLICA. Index=0; erros, falha_*, concluido and aprovado are cleared; ocupado=1.
  - APLICA: a_out/b_out already hold the index. Go to ESPERA if LAT>0, else VERIFICA. Settle counter loads LAT-1.
  - ESPERA: decrement the counter; at 0 -> VERIFICA.
  - VERIFICA: sample the flags and compare against expected (maior=a>b, menor=a<b, igual=a==b, exactly one high).
    - On mismatch: erros+1, saturating at 2^ERR_W-1.
    - On the first mismatch of the sweep: falha_a/falha_b capture the current a/b.
    - If index is all-ones -> FIM. Otherwise increment index, update a_out/b_out on the same edge, -> APLICA.
  - FIM: ocupado=0, concluido=1, aprovado=(erros==0). iniciar=1 restarts exactly as from OCIOSO.
- Timing: cycles per vector = 2+LAT. Total sweep = 2^(2N)·(2+LAT) cycles from the iniciar edge to the concluido rise. N=1, LAT=0 gives 8 cycles.
- iniciar while ocupado=1 is ignored.
- Flag values outside VERIFICA are don't-care and never counted.
- Non-one-hot flags (000, 110, 111, …) always count as a mismatch.
- Saturation: erros stays at max. aprovado is still 0.
- Reset mid-sweep: immediate return to the reset values. No partial result is retained.
- Index width is 2N, so the last vector is detected explicitly. The index never wraps to restart a sweep.

Decomposition:
- Shared package/header holds the state encoding localparams (OCIOSO, APLICA, ESPERA, VERIFICA, FIM) and the golden-relation function esperado(a,b) returning {maior,menor,igual}. The bench's scoreboard reuses that function.
- One natural sub-module: comparador_bist_verif. It is combinational: inputs a, b, flags; output erro. It keeps the checking logic separately testable.
- FSM, counters and capture registers stay in the top module.

Test Plan:
- N=1, LAT=0, correct behavioural 1-bit comparator as DUT; pulse iniciar -> a_out/b_out walk 00,01,10,11; concluido=1 eight cycles after start; erros=0; aprovado=1.
- N=2, LAT=2, DUT with maior stuck at 1 -> 10 mismatches (all a≤b); erros=10; falha_a=0, falha_b=0; aprovado=0; sweep takes 64 cycles.
- N=2, ERR_W=2, DUT flags forced 000 -> erros saturates at 3; aprovado=0; falha_a=0, falha_b=0.
- N=1, DUT igual=0 only for a=1,b=1 -> erros=1; falha_a=1, falha_b=1.
- Mid-sweep rst=1 asserted between clock edges -> all outputs return to reset values without waiting for a clock edge. A following iniciar gives a full clean sweep.
- In FIM, re-pulse iniciar with a corrected DUT -> erros and falha_* clear; new sweep ends with aprovado=1. An iniciar pulse during ocupado has no effect.

Source files
------------

// File: rtl/comparador_bist_pkg.sv
// Shared definitions for the comparator BIST: controller states and the
// golden magnitude relation that the checker and the bench both rely on.
package comparador_bist_pkg;

    localparam int MAX_N = 8;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        APLICA   = 3'd1,
        ESPERA   = 3'd2,
        VERIFICA = 3'd3,
        FIM      = 3'd4
    } estado_t;

    // Golden flags {maior, menor, igual}; always exactly one bit high.
    function automatic logic [2:0] esperado(input logic [MAX_N-1:0] a,
                                            input logic [MAX_N-1:0] b);
        return {a > b, a < b, a == b};
    endfunction

endpackage

// File: rtl/comparador_bist_verif.sv
// Combinational checker: flags one comparator vector whose flags differ
// from the golden relation (non-one-hot patterns can never match it).
module comparador_bist_verif
    import comparador_bist_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         maior_i,
    input  logic         menor_i,
    input  logic         igual_i,
    output logic         erro_o
);

    assign erro_o = ({maior_i, menor_i, igual_i} != esperado(MAX_N'(a_i), MAX_N'(b_i)));

endmodule

// File: rtl/comparador_bist.sv
// BIST controller for an N-bit magnitude comparator: exhaustive (a,b) sweep,
// programmable settle time, saturating error count and first-failure capture.
module comparador_bist
    import comparador_bist_pkg::*;
#(
    parameter int N     = 1,
    parameter int LAT   = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    output logic [N-1:0]     a_out,
    output logic [N-1:0]     b_out,
    input  logic             maior_in,
    input  logic             menor_in,
    input  logic             igual_in,
    output logic             ocupado,
    output logic             concluido,
    output logic             aprovado,
    output logic [ERR_W-1:0] erros,
    output logic [N-1:0]     falha_a,
    output logic [N-1:0]     falha_b
);

    localparam int               IW       = 2 * N;
    localparam logic [IW-1:0]    IDX_ULT  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [3:0]       CNT_INI  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    estado_t          estado_q, estado_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] erros_q, erros_d;
    logic [N-1:0]     falha_a_q, falha_a_d;
    logic [N-1:0]     falha_b_q, falha_b_d;
    logic             ocupado_q, ocupado_d;
    logic             concluido_q, concluido_d;
    logic             aprovado_q, aprovado_d;
    logic             erro;

    // The index register is the operand pair; b sits in the low half so it
    // is the inner loop of the sweep.
    comparador_bist_verif #(.N(N)) u_verif (
        .a_i     (idx_q[IW-1:N]),
        .b_i     (idx_q[N-1:0]),
        .maior_i (maior_in),
        .menor_i (menor_in),
        .igual_i (igual_in),
        .erro_o  (erro)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no
        // branch below can leave one unassigned and infer a latch.
        estado_d    = estado_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        erros_d     = erros_q;
        falha_a_d   = falha_a_q;
        falha_b_d   = falha_b_q;
        ocupado_d   = ocupado_q;
        concluido_d = concluido_q;
        aprovado_d  = aprovado_q;

        case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_d    = APLICA;
                    idx_d       = '0;
                    erros_d     = '0;
                    falha_a_d   = '0;
                    falha_b_d   = '0;
                    concluido_d = 1'b0;
                    aprovado_d  = 1'b0;
                    ocupado_d   = 1'b1;
                end
            end
            APLICA: begin
                cnt_d    = CNT_INI;
                estado_d = (LAT > 0) ? ESPERA : VERIFICA;
            end
            ESPERA: begin
                if (cnt_q == 4'd0) estado_d = VERIFICA;
                else               cnt_d    = cnt_q - 4'd1;
            end
            VERIFICA: begin
                if (erro) begin
                    if (erros_q != ERR_MAX) erros_d = erros_q + 1'b1;
                    // A saturated counter never returns to zero, so this
                    // only fires on the first failing vector of a sweep.
                    if (erros_q == '0) begin
                        falha_a_d = idx_q[IW-1:N];
                        falha_b_d = idx_q[N-1:0];
                    end
                end
                if (idx_q == IDX_ULT) begin
                    estado_d    = FIM;
                    ocupado_d   = 1'b0;
                    concluido_d = 1'b1;
                    aprovado_d  = (erros_d == '0);
                end else begin
                    idx_d    = idx_q + 1'b1;
                    estado_d = APLICA;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            estado_q    <= OCIOSO;
            idx_q       <= '0;
            cnt_q       <= '0;
            erros_q     <= '0;
            falha_a_q   <= '0;
            falha_b_q   <= '0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            aprovado_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            erros_q     <= erros_d;
            falha_a_q   <= falha_a_d;
            falha_b_q   <= falha_b_d;
            ocupado_q   <= ocupado_d;
            concluido_q <= concluido_d;
            aprovado_q  <= aprovado_d;
        end
    end

    assign a_out     = idx_q[IW-1:N];
    assign b_out     = idx_q[N-1:0];
    assign ocupado   = ocupado_q;
    assign concluido = concluido_q;
    assign aprovado  = aprovado_q;
    assign erros     = erros_q;
    assign falha_a   = falha_a_q;
    assign falha_b   = falha_b_q;

endmodule
